// File: rtl/uart_tx_fifo.sv
// Buffered async serial transmitter: FIFO feeding a start/data/parity/stop framer.
// Latency: a write into an empty idle FIFO is popped on the next edge, start bit follows that edge.
// Backpressure: none toward the writer; writes while full are dropped and flagged in sticky overflow.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   wr_en, din      push din[DATA_BITS-1:0] when not full
//   tx_en           permits a new frame to start (a running frame always completes)
//   clr_ovf         clears the sticky overflow flag (a same-cycle set wins)
//   TxD             serial line, idles high
//   full, empty     registered FIFO flags
//   level           registered FIFO occupancy
//   busy            frame in progress or data queued
//   tx_done         one-cycle pulse on the last cycle of each frame
//   overflow        sticky, set by a write while full
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int DEPTH        = 16,
  parameter int ADDR_W       = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [7:0]        din,
  input  logic              tx_en,
  input  logic              clr_ovf,
  output logic              TxD,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   level,
  output logic              busy,
  output logic              tx_done,
  output logic              overflow
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]   BCNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [ADDR_W:0] LVL_FULL  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] LVL_ONE   = (ADDR_W + 1)'(1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  // ---------------------------------------------------------------- FIFO
  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [ADDR_W-1:0]    wptr;
  logic [ADDR_W-1:0]    rptr;
  logic [ADDR_W:0]      level_nxt;
  logic [DATA_BITS-1:0] head;
  logic                 push;
  logic                 pop;

  // Upper din bits beyond DATA_BITS are deliberately discarded.
  logic unused_din;
  assign unused_din = ^din;

  // full is the registered flag, so a pop in the same cycle never frees room for a write.
  assign push = wr_en && !full;
  assign head = mem[rptr];

  always_comb begin
    level_nxt = level;
    if (push && !pop) begin
      level_nxt = level + LVL_ONE;
    end else if (!push && pop) begin
      level_nxt = level - LVL_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= din[DATA_BITS-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      level    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (push) wptr <= wptr + ADDR_W'(1);
      if (pop)  rptr <= rptr + ADDR_W'(1);
      level <= level_nxt;
      full  <= (level_nxt == LVL_FULL);
      empty <= (level_nxt == '0);
      if (wr_en && full) begin
        overflow <= 1'b1;
      end else if (clr_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------- framer
  state_t               state, state_d;
  logic [CW-1:0]        bcnt, bcnt_d;
  logic [2:0]           bidx, bidx_d;
  logic [DATA_BITS-1:0] shift, shift_d;
  logic                 par_bit, par_d;
  logic                 txd_d;
  logic                 period_end;
  logic                 start_ok;
  logic                 do_load;

  assign period_end = (bcnt == BCNT_LAST);
  assign start_ok   = !empty && tx_en;
  assign busy       = (state != IDLE) || !empty;

  always_comb begin
    state_d = state;
    bcnt_d  = bcnt;
    bidx_d  = bidx;
    shift_d = shift;
    par_d   = par_bit;
    txd_d   = TxD;
    do_load = 1'b0;
    pop     = 1'b0;
    tx_done = 1'b0;

    if (state == IDLE) begin
      bcnt_d = '0;
    end else begin
      bcnt_d = period_end ? '0 : bcnt + CW'(1);
    end

    case (state)
      IDLE: begin
        if (start_ok) do_load = 1'b1;
      end
      START: begin
        if (period_end) begin
          state_d = DATA;
          txd_d   = shift[0];
        end
      end
      DATA: begin
        if (period_end) begin
          shift_d = shift >> 1;
          if (bidx == 3'(DATA_BITS - 1)) begin
            bidx_d = '0;
            if (PARITY != 0) begin
              state_d = PAR;
              txd_d   = par_bit;
            end else begin
              state_d = STOP;
              txd_d   = 1'b1;
            end
          end else begin
            bidx_d = bidx + 3'd1;
            txd_d  = shift[1];
          end
        end
      end
      PAR: begin
        if (period_end) begin
          state_d = STOP;
          txd_d   = 1'b1;
        end
      end
      STOP: begin
        if (period_end) begin
          if (bidx == 3'(STOP_BITS - 1)) begin
            tx_done = 1'b1;
            bidx_d  = '0;
            // Chain straight into the next start bit so frames leave back-to-back.
            if (start_ok) begin
              do_load = 1'b1;
            end else begin
              state_d = IDLE;
              txd_d   = 1'b1;
            end
          end else begin
            bidx_d = bidx + 3'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        txd_d   = 1'b1;
      end
    endcase

    // Parity is captured at load time because the shift register is consumed while sending.
    if (do_load) begin
      pop     = 1'b1;
      shift_d = head;
      par_d   = (PARITY == 1) ? ~(^head) : ^head;
      state_d = START;
      bcnt_d  = '0;
      bidx_d  = '0;
      txd_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      bcnt    <= '0;
      bidx    <= '0;
      shift   <= '0;
      par_bit <= 1'b0;
      TxD     <= 1'b1;
    end else begin
      state   <= state_d;
      bcnt    <= bcnt_d;
      bidx    <= bidx_d;
      shift   <= shift_d;
      par_bit <= par_d;
      TxD     <= txd_d;
    end
  end

endmodule
